// File: rtl/pmem_arb_pkg.sv
// Shared types for the physical-memory arbiter: FSM states, grant encoding
// and priority-mode selectors.
package pmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D
   } arb_state_t;

   typedef enum logic {
      GNT_I,
      GNT_D
   } grant_t;

   localparam int PRIO_RR      = 0;
   localparam int PRIO_FIXED_I = 1;

endpackage

// File: rtl/pmem_arbiter_rr2.sv
// Two-way requester picker: req_i[0] is the I-cache, req_i[1] the D-cache.
// Ties go to the side that was not granted last, or always to I in fixed mode.
module arb_rr2
   import pmem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  grant_t     last_grant_i,
   input  logic       mode_i,
   output grant_t     grant_o
);

   always_comb begin
      grant_o = GNT_I;
      case (req_i)
         2'b10: grant_o = GNT_D;
         2'b11: if (!mode_i && last_grant_i == GNT_I) grant_o = GNT_D;
         default: grant_o = GNT_I;
      endcase
   end

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates the single pmem line port between the I-cache (read only) and
// the D-cache (read/write), one latched transaction at a time.
module pmem_arbiter
   import pmem_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int LINE_W    = 256,
   parameter int PRIO_MODE = PRIO_RR
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_addr,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   arb_state_t        state_q, state_d;
   grant_t            last_grant_q, last_grant_d;
   grant_t            pick;
   logic              op_write_q, op_write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic [LINE_W-1:0] i_rdata_q, d_rdata_q;
   logic              i_req, d_req;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   arb_rr2 u_pick (
      .req_i        ({d_req, i_req}),
      .last_grant_i (last_grant_q),
      .mode_i       (PRIO_MODE == PRIO_FIXED_I),
      .grant_o      (pick)
   );

   // Requests are only sampled in IDLE; a write wins over a simultaneous read.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_write_d   = op_write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      i_resp       = 1'b0;
      d_resp       = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               last_grant_d = pick;
               if (pick == GNT_I) begin
                  state_d    = SERVE_I;
                  op_write_d = 1'b0;
                  addr_d     = i_addr;
                  wdata_d    = '0;
               end else begin
                  state_d    = SERVE_D;
                  op_write_d = d_write;
                  addr_d     = d_addr;
                  wdata_d    = d_wdata;
               end
            end
         end
         SERVE_I: begin
            pmem_read = 1'b1;
            if (pmem_resp) begin
               i_resp  = 1'b1;
               state_d = IDLE;
            end
         end
         SERVE_D: begin
            pmem_read  = ~op_write_q;
            pmem_write = op_write_q;
            if (pmem_resp) begin
               d_resp  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pmem_addr  = addr_q;
   assign pmem_wdata = wdata_q;
   assign i_rdata    = i_resp ? pmem_rdata : i_rdata_q;
   assign d_rdata    = (d_resp && !op_write_q) ? pmem_rdata : d_rdata_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         last_grant_q <= GNT_D;
         op_write_q   <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_write_q   <= op_write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         i_rdata_q    <= i_rdata;
         d_rdata_q    <= d_rdata;
      end
   end

   a_no_rd_and_wr: assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed literal checks, then random
// cache/pmem traffic compared every cycle against a transaction-level model.
module tb_pmem_arbiter;
   localparam int AW = 32;
   localparam int LW = 256;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          rstN;
   logic          iRead, dRead, dWrite, pmemResp;
   logic [AW-1:0] iAddr, dAddr;
   logic [LW-1:0] dWdata, pmemRdata;
   logic [LW-1:0] iRdata, dRdata, pmemWdata;
   logic [AW-1:0] pmemAddr;
   logic          iResp, dResp, pmemRead, pmemWrite;

   logic          rst1;
   logic [LW-1:0] iRdata1, dRdata1, pmemWdata1, pmemRdata1;
   logic [AW-1:0] pmemAddr1;
   logic          iResp1, dResp1, pmemRead1, pmemWrite1;

   int total = 0;
   int bad   = 0;

   pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .PRIO_MODE(0)) dut (
      .clk(clock), .rst(rstN),
      .i_read(iRead), .i_addr(iAddr), .i_rdata(iRdata), .i_resp(iResp),
      .d_read(dRead), .d_write(dWrite), .d_addr(dAddr), .d_wdata(dWdata),
      .d_rdata(dRdata), .d_resp(dResp),
      .pmem_read(pmemRead), .pmem_write(pmemWrite), .pmem_addr(pmemAddr),
      .pmem_wdata(pmemWdata), .pmem_rdata(pmemRdata), .pmem_resp(pmemResp)
   );

   pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .PRIO_MODE(1)) dutFixed (
      .clk(clock), .rst(rst1),
      .i_read(1'b1), .i_addr(32'h0000_0100), .i_rdata(iRdata1), .i_resp(iResp1),
      .d_read(1'b1), .d_write(1'b0), .d_addr(32'h0000_0200), .d_wdata({LW{1'b1}}),
      .d_rdata(dRdata1), .d_resp(dResp1),
      .pmem_read(pmemRead1), .pmem_write(pmemWrite1), .pmem_addr(pmemAddr1),
      .pmem_wdata(pmemWdata1), .pmem_rdata(pmemRdata1), .pmem_resp(1'b1)
   );

   // Model: which cache owns pmem (0 none, 1 I, 2 D), the transaction it owns,
   // who was granted last, and the line each cache last received.
   int            serving;
   bit            lastWasD;
   bit            curWrite;
   logic [AW-1:0] curAddr;
   logic [LW-1:0] curWdata;
   logic [LW-1:0] heldI, heldD;
   bit            eIResp, eDResp;

   task automatic cmp(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [LW-1:0] randLine();
      logic [LW-1:0] v;
      for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
      return v;
   endfunction

   task automatic resetModel();
      serving  = 0;
      lastWasD = 1'b1;
      curWrite = 1'b0;
      curAddr  = '0;
      curWdata = '0;
      heldI    = '0;
      heldD    = '0;
   endtask

   task automatic checkOutput();
      bit eRd, eWr;
      eRd    = (serving == 1) || (serving == 2 && !curWrite);
      eWr    = (serving == 2) && curWrite;
      eIResp = (serving == 1) && pmemResp;
      eDResp = (serving == 2) && pmemResp;
      cmp("pmem_read", pmemRead, eRd);
      cmp("pmem_write", pmemWrite, eWr);
      cmp("i_resp", iResp, eIResp);
      cmp("d_resp", dResp, eDResp);
      cmp("i_rdata", iRdata, eIResp ? pmemRdata : heldI);
      cmp("d_rdata", dRdata, (eDResp && !curWrite) ? pmemRdata : heldD);
      if (serving != 0) cmp("pmem_addr", pmemAddr, curAddr);
      if (eWr) cmp("pmem_wdata", pmemWdata, curWdata);
   endtask

   task automatic updateModel();
      bit iq, dq, goI;
      if (!rstN) begin
         resetModel();
      end else begin
         if (eIResp) heldI = pmemRdata;
         if (eDResp && !curWrite) heldD = pmemRdata;
         if (serving == 0) begin
            iq = iRead;
            dq = dRead | dWrite;
            if (iq || dq) begin
               goI      = iq && (!dq || lastWasD);
               lastWasD = !goI;
               serving  = goI ? 1 : 2;
               curWrite = goI ? 1'b0 : dWrite;
               curAddr  = goI ? iAddr : dAddr;
               curWdata = goI ? '0 : dWdata;
            end
         end else if (pmemResp) begin
            serving = 0;
         end
      end
   endtask

   task automatic sampleHalf();
      @(negedge clock);
      checkOutput();
   endtask

   task automatic finishCycle();
      @(posedge clock);
      updateModel();
      #2;
   endtask

   // Caches hold a request until its response, then may immediately issue another.
   task automatic applyStimulus();
      if (!rstN) begin
         iRead = 1'b0; dRead = 1'b0; dWrite = 1'b0;
      end else begin
         if (iRead && eIResp) iRead = 1'b0;
         if ((dRead || dWrite) && eDResp) begin dRead = 1'b0; dWrite = 1'b0; end
         if (iRead && $urandom_range(0, 3) == 0) iAddr = $urandom() & ~32'h1f;
         if (!iRead && $urandom_range(0, 2) != 0) begin
            iRead = 1'b1;
            iAddr = $urandom() & ~32'h1f;
         end
         if (!dRead && !dWrite && $urandom_range(0, 2) != 0) begin
            if ($urandom_range(0, 1) == 1) dWrite = 1'b1; else dRead = 1'b1;
            dAddr  = $urandom() & ~32'h1f;
            dWdata = randLine();
         end
      end
      rstN      = ($urandom_range(0, 199) != 0);
      pmemResp  = ($urandom_range(0, 2) == 0);
      pmemRdata = randLine();
   endtask

   initial begin
      logic [LW-1:0] wPat;
      resetModel();
      rstN = 1'b0; rst1 = 1'b0;
      iRead = 1'b1; iAddr = 32'h0000_1040;
      dRead = 1'b0; dWrite = 1'b0; dAddr = '0; dWdata = '0;
      pmemResp = 1'b0; pmemRdata = '0; pmemRdata1 = '0;
      eIResp = 1'b0; eDResp = 1'b0;

      finishCycle();
      sampleHalf();
      cmp("rst_pmem_read", pmemRead, 1'b0);
      cmp("rst_i_resp", iResp, 1'b0);
      cmp("rst_pmem_addr", pmemAddr, 32'h0);
      cmp("rst_i_rdata", iRdata, '0);
      finishCycle();
      rstN = 1'b1;
      sampleHalf();
      cmp("idle_pmem_read", pmemRead, 1'b0);
      finishCycle();
      sampleHalf();
      cmp("grant_i_pmem_read", pmemRead, 1'b1);
      cmp("grant_i_pmem_addr", pmemAddr, 32'h0000_1040);
      finishCycle(); sampleHalf(); finishCycle();
      pmemResp = 1'b1; pmemRdata = {8{32'hA5A5_A5A5}};
      sampleHalf();
      cmp("lone_i_resp", iResp, 1'b1);
      cmp("lone_i_rdata", iRdata, {8{32'hA5A5_A5A5}});
      cmp("lone_d_resp", dResp, 1'b0);
      finishCycle();
      iRead = 1'b0; pmemResp = 1'b0; pmemRdata = '0;
      sampleHalf();
      cmp("i_resp_one_cycle", iResp, 1'b0);
      cmp("i_rdata_hold", iRdata, {8{32'hA5A5_A5A5}});
      finishCycle();

      wPat = {4{64'h0123_4567_89AB_CDEF}};
      dWrite = 1'b1; dAddr = 32'h8000_0000; dWdata = wPat;
      sampleHalf();
      cmp("wb_idle_write", pmemWrite, 1'b0);
      finishCycle();
      pmemResp = 1'b1; pmemRdata = {8{32'h5A5A_5A5A}};
      sampleHalf();
      cmp("wb_pmem_write", pmemWrite, 1'b1);
      cmp("wb_pmem_read", pmemRead, 1'b0);
      cmp("wb_pmem_addr", pmemAddr, 32'h8000_0000);
      cmp("wb_pmem_wdata", pmemWdata, wPat);
      cmp("wb_d_resp", dResp, 1'b1);
      cmp("wb_d_rdata_untouched", dRdata, '0);
      finishCycle();
      dWrite = 1'b0; pmemResp = 1'b0;
      sampleHalf();
      cmp("wb_d_resp_drop", dResp, 1'b0);
      finishCycle();

      rstN = 1'b0; iRead = 1'b1; iAddr = 32'h0000_2000; dRead = 1'b1; dAddr = 32'h0000_3000;
      sampleHalf(); finishCycle();
      rstN = 1'b1;
      sampleHalf(); finishCycle();
      pmemResp = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sampleHalf();
         cmp("rr_i_resp", iResp, (k % 2) == 0);
         cmp("rr_d_resp", dResp, (k % 2) == 1);
         cmp("rr_addr", pmemAddr, (k % 2) == 0 ? 32'h0000_2000 : 32'h0000_3000);
         finishCycle();
         if (k == 3) begin iRead = 1'b0; dRead = 1'b0; end
         sampleHalf();
         cmp("rr_gap_read", pmemRead, 1'b0);
         finishCycle();
      end
      sampleHalf();
      cmp("spurious_i_resp", iResp, 1'b0);
      cmp("spurious_d_resp", dResp, 1'b0);
      finishCycle();

      pmemResp = 1'b0; dWrite = 1'b1; dAddr = 32'h0000_4000; dWdata = randLine();
      sampleHalf(); finishCycle();
      sampleHalf();
      cmp("abort_pre_write", pmemWrite, 1'b1);
      finishCycle();
      rstN = 1'b0;
      sampleHalf(); finishCycle();
      rstN = 1'b1; dWrite = 1'b0; pmemResp = 1'b1;
      sampleHalf();
      cmp("abort_write", pmemWrite, 1'b0);
      cmp("abort_d_resp", dResp, 1'b0);
      finishCycle();

      repeat (3000) begin
         applyStimulus();
         sampleHalf();
         finishCycle();
      end

      rst1 = 1'b1;
      for (int k = 0; k < 8; k++) begin
         pmemRdata1 = randLine();
         @(negedge clock);
         cmp("fixed_i_resp", iResp1, (k % 2) == 1);
         cmp("fixed_d_resp", dResp1, 1'b0);
         cmp("fixed_read", pmemRead1, (k % 2) == 1);
         cmp("fixed_write", pmemWrite1, 1'b0);
         if (k % 2 == 1) begin
            cmp("fixed_addr", pmemAddr1, 32'h0000_0100);
            cmp("fixed_wdata", pmemWdata1, '0);
            cmp("fixed_i_rdata", iRdata1, pmemRdata1);
         end
         cmp("fixed_d_rdata", dRdata1, '0);
         @(posedge clock);
         #2;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
